// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light controller and its lamp driver:
// vehicle code constants, driver state encoding and small decode helpers.
package semaforo_pkg;

  // Vehicle codes produced by the controller, one per direction.
  localparam logic [1:0] VERDE    = 2'd0;
  localparam logic [1:0] AMARELO  = 2'd1;
  localparam logic [1:0] VERMELHO = 2'd2;
  localparam logic [1:0] INVALIDO = 2'd3;

  // Saturation value of the 4-bit conflict counter.
  localparam logic [3:0] CONF_CNT_MAX = 4'd15;

  // Driver state: FAULT is a latched flashing-yellow fail-safe.
  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } drv_state_e;

  // One direction's vehicle lamps.
  typedef struct packed {
    logic grn;
    logic yel;
    logic red;
  } veh_lamp_t;

  // One crossing's pedestrian lamps.
  typedef struct packed {
    logic walk;
    logic stop;
  } ped_lamp_t;

  // Unsafe or invalid input combination.
  function automatic logic is_conflict(input logic [1:0] c1, input logic [1:0] c2,
                                       input logic p1, input logic p2);
    return ((c1 != VERMELHO) && (c2 != VERMELHO)) ||
           (c1 == INVALIDO) || (c2 == INVALIDO) ||
           (p1 && p2);
  endfunction

  // One-hot vehicle decode; an invalid code shows red.
  function automatic veh_lamp_t decode_vehicle(input logic [1:0] code);
    veh_lamp_t l;
    case (code)
      VERDE:    l = '{grn: 1'b1, yel: 1'b0, red: 1'b0};
      AMARELO:  l = '{grn: 1'b0, yel: 1'b1, red: 1'b0};
      VERMELHO: l = '{grn: 1'b0, yel: 1'b0, red: 1'b1};
      default:  l = '{grn: 1'b0, yel: 1'b0, red: 1'b1};
    endcase
    return l;
  endfunction

  // Pedestrian decode: walk on green, blinking walk on yellow, stop otherwise.
  function automatic ped_lamp_t decode_ped(input logic p, input logic [1:0] code,
                                           input logic blink);
    ped_lamp_t l;
    if (p && (code == VERDE)) begin
      l = '{walk: 1'b1, stop: 1'b0};
    end else if (p && (code == AMARELO)) begin
      l = '{walk: blink, stop: 1'b0};
    end else begin
      l = '{walk: 1'b0, stop: 1'b1};
    end
    return l;
  endfunction

endpackage

// File: rtl/semaforo_driver_pisca.sv
// Blink generator: square wave of period 2*BLINK_DIV clocks. The output is
// the blink value that applies at the coming clock edge, so a restart shows
// a lit lamp on the very edge it is requested.
module pisca #(
  parameter int unsigned BLINK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic blink
);

  localparam logic [3:0] LAST = 4'(BLINK_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       blink_q, blink_d;

  // Next-state: restart forces a lit phase, otherwise count and toggle on wrap.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (restart) begin
      cnt_d   = 4'd0;
      blink_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d   = 4'd0;
      blink_d = ~blink_q;
    end else begin
      cnt_d   = cnt_q + 4'd1;
      blink_d = blink_q;
    end
  end

  // Counter and blink registers; reset starts lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_d;

endmodule

// File: rtl/semaforo_driver.sv
// Lamp driver downstream of the traffic-light controller: registers the
// controller codes into one-hot lamps, blinks the walk lamp on yellow and
// latches a flashing-yellow fail-safe after a sustained input conflict.
module semaforo_driver
  import semaforo_pkg::*;
#(
  parameter int unsigned BLINK_DIV       = 2,
  parameter int unsigned CONFLICT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic       p1,
  input  logic       p2,
  output logic       v1_grn,
  output logic       v1_yel,
  output logic       v1_red,
  output logic       v2_grn,
  output logic       v2_yel,
  output logic       v2_red,
  output logic       p1_walk,
  output logic       p1_stop,
  output logic       p2_walk,
  output logic       p2_stop,
  output logic       fault
);

  localparam logic [3:0] CONFLICT_N = 4'(CONFLICT_CYCLES);

  drv_state_e state_q, state_d;
  logic [3:0] conf_cnt_q, conf_cnt_d;
  logic [1:0] c1_prev_q, c1_prev_d;
  logic [1:0] c2_prev_q, c2_prev_d;
  veh_lamp_t  v1_q, v1_d, v2_q, v2_d;
  ped_lamp_t  ped1_q, ped1_d, ped2_q, ped2_d;
  logic       fault_q, fault_d;

  logic conflict;
  logic fault_entry;
  logic yellow_start;
  logic restart;
  logic blink;

  // Conflict filter, state transition and blink-restart requests.
  always_comb begin
    conflict = is_conflict(c1, c2, p1, p2);
    if (conflict) begin
      if (conf_cnt_q == CONF_CNT_MAX) begin
        conf_cnt_d = CONF_CNT_MAX;
      end else begin
        conf_cnt_d = conf_cnt_q + 4'd1;
      end
    end else begin
      conf_cnt_d = 4'd0;
    end

    fault_entry = 1'b0;
    case (state_q)
      NORMAL: begin
        if (conflict && (conf_cnt_d == CONFLICT_N)) begin
          state_d     = FAULT;
          fault_entry = 1'b1;
        end else begin
          state_d = NORMAL;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    c1_prev_d    = c1;
    c2_prev_d    = c2;
    yellow_start = ((c1 == AMARELO) && (c1_prev_q != AMARELO)) ||
                   ((c2 == AMARELO) && (c2_prev_q != AMARELO));
    restart      = fault_entry || yellow_start;
  end

  pisca #(
    .BLINK_DIV(BLINK_DIV)
  ) u_pisca (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .blink  (blink)
  );

  // Lamp decode for the state being entered, so lamps change with the state.
  always_comb begin
    if (state_d == FAULT) begin
      v1_d    = '{grn: 1'b0, yel: blink, red: 1'b0};
      v2_d    = '{grn: 1'b0, yel: blink, red: 1'b0};
      ped1_d  = '{walk: 1'b0, stop: 1'b0};
      ped2_d  = '{walk: 1'b0, stop: 1'b0};
      fault_d = 1'b1;
    end else begin
      v1_d    = decode_vehicle(c1);
      v2_d    = decode_vehicle(c2);
      ped1_d  = decode_ped(p1, c1, blink);
      ped2_d  = decode_ped(p2, c2, blink);
      fault_d = 1'b0;
    end
  end

  // State, conflict counter, previous codes and registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      conf_cnt_q <= 4'd0;
      c1_prev_q  <= VERMELHO;
      c2_prev_q  <= VERMELHO;
      v1_q       <= 3'b001;
      v2_q       <= 3'b001;
      ped1_q     <= 2'b01;
      ped2_q     <= 2'b01;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      conf_cnt_q <= conf_cnt_d;
      c1_prev_q  <= c1_prev_d;
      c2_prev_q  <= c2_prev_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      ped1_q     <= ped1_d;
      ped2_q     <= ped2_d;
      fault_q    <= fault_d;
    end
  end

  assign v1_grn  = v1_q.grn;
  assign v1_yel  = v1_q.yel;
  assign v1_red  = v1_q.red;
  assign v2_grn  = v2_q.grn;
  assign v2_yel  = v2_q.yel;
  assign v2_red  = v2_q.red;
  assign p1_walk = ped1_q.walk;
  assign p1_stop = ped1_q.stop;
  assign p2_walk = ped2_q.walk;
  assign p2_stop = ped2_q.stop;
  assign fault   = fault_q;

endmodule

// File: doc/semaforo_driver.md
# semaforo_driver

Lamp-driver stage placed directly downstream of the two-way traffic-light controller. It takes the controller's encoded vehicle codes (c1, c2) and pedestrian enables (p1, p2), registers them into one-hot lamp outputs, and blinks the pedestrian walk lamp during the yellow phase. It also runs a conflict monitor: if the inputs describe an unsafe or invalid combination for CONFLICT_CYCLES consecutive cycles, it latches a flashing-yellow fail-safe mode that only reset clears.

## Interface
- BLINK_DIV, default 2: clock cycles per blink half-period; legal range 1..15.
- CONFLICT_CYCLES, default 2: consecutive conflicting samples needed to enter FAULT; legal range 1..15.
- clk  in  1  system clock; the same clock that drives the controller.
- rst_n  in  1  asynchronous, active-low reset.
- c1, c2  in  2 each  vehicle code per direction: 0 green, 1 yellow, 2 red, 3 invalid.
- p1, p2  in  1 each  pedestrian walk enable per crossing.
- v1_grn, v1_yel, v1_red  out  1 each  direction-1 vehicle lamps.
- v2_grn, v2_yel, v2_red  out  1 each  direction-2 vehicle lamps.
- p1_walk, p1_stop, p2_walk, p2_stop  out  1 each  pedestrian lamps.
- fault  out  1  high while latched in FAULT.

## Operation
- States: NORMAL and FAULT. Reset state is NORMAL.
- Conflict condition, evaluated each cycle on the sampled inputs. It is true when any of these holds:
  - c1 != 2 and c2 != 2, i.e. both directions non-red;
  - c1 == 3 or c2 == 3;
  - p1 and p2 are both 1.
- Conflict counter, 4 bits:
  - increments on every cycle where the condition is true;
  - clears to 0 on any cycle where the condition is false;
  - saturates at 15.
- NORMAL to FAULT: taken on the edge where the counter reaches CONFLICT_CYCLES, i.e. the CONFLICT_CYCLES-th consecutive conflicting sample.
- FAULT has no exit except rst_n low.
- NORMAL decode, registered:
  - vehicle lamps are one-hot from the code;
  - code 3 decodes as red for that direction while still in NORMAL.
- Pedestrian lamps, crossing i, in NORMAL:
  - pi=1 and ci=green: walk=1, stop=0.
  - pi=1 and ci=yellow: walk=blink, stop=0.
  - any other case: walk=0, stop=1.
- FAULT outputs:
  - all green and red lamps 0;
  - v1_yel = v2_yel = blink;
  - all pedestrian lamps 0;
  - fault=1.
- Blink generator:
  - a counter runs 0..BLINK_DIV-1 and wraps;
  - the blink bit toggles on each wrap.
- Blink resets: the blink counter is cleared and blink set to 1 on reset, on NORMAL-to-FAULT entry, and on the first cycle of any yellow phase (ci changes to yellow). Flashing therefore always starts lit.

## Timing
- All outputs are registered. Latency is 1 clock from input sample to lamp change.
- Reset values:
  - v1_red = v2_red = p1_stop = p2_stop = 1;
  - every other output 0;
  - state NORMAL, conflict counter 0, blink = 1, blink counter 0.
- Reset is asynchronous: asserting rst_n mid-operation, including in FAULT, forces the reset values immediately, with no clock needed. Release is sampled on the next clk edge.
- Conflict condition true at edges e1..eN, with N = CONFLICT_CYCLES:
  - edges e1..eN-1 produce the NORMAL decode;
  - edge eN produces the FAULT pattern and fault=1.
- A single non-conflicting sample before eN restarts the count. A 1-cycle glitch never faults when CONFLICT_CYCLES ≥ 2.
- With CONFLICT_CYCLES=1, fault asserts on the first edge that samples a conflict.
- If a yellow phase starts on the same edge that FAULT is entered, the FAULT blink restart takes priority; the result is identical (blink=1, counter 0).
- Blink period is 2·BLINK_DIV cycles. With BLINK_DIV=1, blink toggles every cycle.

## Structure
- Shared package semaforo_pkg:
  - code constants VERDE=2'd0, AMARELO=2'd1, VERMELHO=2'd2, INVALIDO=2'd3, shared with the controller;
  - driver state encoding NORMAL / FAULT.
- One sub-module, pisca:
  - parameter BLINK_DIV; inputs clk, rst_n, restart; output blink;
  - instantiated once. Both the pedestrian and FAULT yellow flashing use its output.
- The conflict counter, state register and output decode live in semaforo_driver.

## Test plan
All scenarios use BLINK_DIV=2, CONFLICT_CYCLES=2.
- Reset: hold rst_n=0 with c1=0, c2=0 → v1_red=v2_red=p1_stop=p2_stop=1, all else 0, fault=0. Release → lamps follow the inputs one edge later.
- Normal cycle: drive the controller sequence (c1,c2,p1,p2) = (0,2,1,0)×4, (1,2,1,0)×2, (2,0,0,1)×4, (2,1,0,1)×2 → one-hot lamps lag by 1 cycle; p1_walk during c1 yellow reads 1,1 (first half-period after restart); no fault.
- Glitch filter: one cycle of c1=0, c2=0, then c2=2 → counter back to 0, fault stays 0, v2_grn high for exactly one cycle.
- Fault entry: c1=0, c2=1 held for 2 cycles → fault=1 on the 2nd edge; greens 0; v1_yel/v2_yel read 1,1,0,0,1,1…; all pedestrian lamps 0. Restoring valid inputs keeps fault=1.
- Invalid code: c2=3 with c1=2 → v2_red=1 on the first edge, fault=1 on the second. A separate run with p1=p2=1 and c1=2, c2=2 → fault after 2 edges.
- Async reset in FAULT: pull rst_n low between clock edges → outputs return to reset values before the next edge. After release with valid inputs, normal decode resumes.
